// File: rtl/commit_trace_pkg.sv
// Shared types and helpers for the commit trace producer: record kinds,
// serializer states, entry width and the per-kind word sequencing.
package commit_trace_pkg;

  localparam int INUM_W_DEF = 16;
  localparam int ENTRY_W    = 3 + 3 + INUM_W_DEF + 64;

  typedef enum logic [2:0] {
    K_NOP  = 3'd0,
    K_REG  = 3'd1,
    K_LD   = 3'd2,
    K_STU  = 3'd3,
    K_ST   = 3'd4,
    K_HALT = 3'd5
  } kind_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_INUM  = 3'd2,
    S_PC    = 3'd3,
    S_VAL   = 3'd4,
    S_ADDR  = 3'd5,
    S_MDATA = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  // Number of 16-bit words in a record of the given kind.
  function automatic logic [2:0] word_count(kind_t k);
    logic [2:0] n;
    case (k)
      K_REG:   n = 3'd4;
      K_LD:    n = 3'd5;
      K_ST:    n = 3'd5;
      K_STU:   n = 3'd6;
      default: n = 3'd3;
    endcase
    return n;
  endfunction

  // Store-with-writeback wins over load, register write over halt, halt over plain store.
  function automatic kind_t classify(logic reg_write, logic mem_read, logic mem_write, logic halt);
    kind_t k;
    if (reg_write && mem_write)     k = K_STU;
    else if (reg_write && mem_read) k = K_LD;
    else if (reg_write)             k = K_REG;
    else if (halt)                  k = K_HALT;
    else if (mem_write)             k = K_ST;
    else                            k = K_NOP;
    return k;
  endfunction

  // State that follows word s of a record of kind k; S_IDLE marks end of record.
  function automatic state_t next_word(state_t s, kind_t k);
    state_t n;
    n = S_IDLE;
    case (s)
      S_HDR:  n = S_INUM;
      S_INUM: n = S_PC;
      S_PC: begin
        if (k == K_NOP)       n = S_IDLE;
        else if (k == K_HALT) n = S_FIN;
        else if (k == K_ST)   n = S_ADDR;
        else                  n = S_VAL;
      end
      S_VAL:   n = (k == K_REG) ? S_IDLE : S_ADDR;
      S_ADDR:  n = (k == K_LD) ? S_IDLE : S_MDATA;
      S_MDATA: n = S_IDLE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  // True when word s is the final word of a kind-k record.
  function automatic logic is_last_word(state_t s, kind_t k);
    state_t n;
    n = next_word(s, k);
    return (n == S_IDLE) || (n == S_FIN);
  endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// Record FIFO. Exposes the head and the entry behind it so the serializer
// can start the next record in the same cycle the current one is popped.
module commit_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 86
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [W-1:0]             second,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_next = rd_ptr + AW'(1);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign second  = mem[rd_next];

  // Storage array: written on push, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/commit_trace_tx.sv
// Commit trace producer: classifies and numbers each retired instruction,
// buffers the record and streams it as 16-bit words.
// Stream handshake: a word transfers on a cycle where tx_valid and tx_ready
// are both high; once tx_valid rises, tx_valid, tx_data and tx_last hold
// until that transfer.
module commit_trace_tx
  import commit_trace_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int INUM_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [15:0] pc,
  input  logic        reg_write,
  input  logic [2:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        halt,
  output logic        stall,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        done,
  output logic [2:0]  fsm_state
);

  localparam int EW       = 3 + 3 + INUM_W + 64;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int MDATA_LO = 0;
  localparam int ADDR_LO  = 16;
  localparam int VAL_LO   = 32;
  localparam int PC_LO    = 48;
  localparam int INUM_LO  = 64;
  localparam int REG_LO   = 64 + INUM_W;
  localparam int KIND_LO  = 67 + INUM_W;

  logic              halted;
  logic              accept;
  logic              pop;
  logic              full;
  logic              empty;
  logic              next_avail;
  logic [INUM_W-1:0] inum;
  logic [CW-1:0]     count;
  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     head;
  logic [EW-1:0]     second;
  logic [EW-1:0]     next_entry;
  logic [EW-1:0]     cur;
  kind_t             kind_in;
  kind_t             cur_kind;
  state_t            state;
  state_t            nxt;

  // Word presented in state s for entry e.
  function automatic logic [15:0] word_of(state_t s, logic [EW-1:0] e);
    logic [15:0] w;
    w = '0;
    case (s)
      S_HDR:   w = {e[KIND_LO +: 3], e[REG_LO +: 3], 10'b0};
      S_INUM:  w = 16'(e[INUM_LO +: INUM_W]);
      S_PC:    w = e[PC_LO +: 16];
      S_VAL:   w = e[VAL_LO +: 16];
      S_ADDR:  w = e[ADDR_LO +: 16];
      S_MDATA: w = e[MDATA_LO +: 16];
      default: w = '0;
    endcase
    return w;
  endfunction

  assign kind_in    = classify(reg_write, mem_read, mem_write, halt);
  assign stall      = full && !halted;
  assign accept     = commit_valid && !full && !halted;
  assign push_entry = {kind_in, write_reg, inum, pc, write_data, mem_addr, mem_data};
  assign pop        = tx_valid && tx_ready && tx_last;
  assign cur_kind   = kind_t'(cur[KIND_LO +: 3]);
  assign nxt        = next_word(state, cur_kind);
  // Another record is ready right after this pop: already queued behind the
  // head, or being pushed this cycle into an otherwise single-entry FIFO.
  assign next_avail = (count >= CW'(2)) || ((count == CW'(1)) && accept);
  assign next_entry = (count >= CW'(2)) ? second : push_entry;
  assign fsm_state  = state;

  commit_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .second    (second),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Instruction numbering; a HALT closes the stream to further commits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inum   <= '0;
      halted <= 1'b0;
    end else if (accept) begin
      inum <= inum + INUM_W'(1);
      if (kind_in == K_HALT) halted <= 1'b1;
    end
  end

  // Serializer: walks the word sequence of the latched record, chaining
  // straight into the next record when one is available.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cur      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            cur      <= head;
            state    <= S_HDR;
            tx_valid <= 1'b1;
            tx_last  <= 1'b0;
            tx_data  <= word_of(S_HDR, head);
          end
        end
        S_FIN: begin
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
        end
        default: begin
          if (tx_valid && tx_ready) begin
            if (nxt == S_FIN) begin
              state    <= S_FIN;
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              tx_data  <= '0;
              done     <= 1'b1;
            end else if (nxt == S_IDLE) begin
              if (next_avail) begin
                cur      <= next_entry;
                state    <= S_HDR;
                tx_valid <= 1'b1;
                tx_last  <= 1'b0;
                tx_data  <= word_of(S_HDR, next_entry);
              end else begin
                state    <= S_IDLE;
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
                tx_data  <= '0;
              end
            end else begin
              state   <= nxt;
              tx_data <= word_of(nxt, cur);
              tx_last <= is_last_word(nxt, cur_kind);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_commit_trace_tx.sv
// Bench for commit_trace_tx: directed commits, a word-level reference queue
// built from the record format, and an every-cycle compare process.
module tb_commit_trace_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [15:0] pc;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        halt;
  logic        stall;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;
  logic        done;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] exp_q[$];
  logic        exp_last_q[$];
  logic        exp_halt_q[$];
  int          occ = 0;
  logic [15:0] m_inum = '0;
  logic        m_halted = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] got_q[$];
  int          hs_count = 0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;

  // Clock / reset
  always #5 clk = ~clk;

  commit_trace_tx #(.DEPTH(DEPTH), .INUM_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .pc           (pc),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .halt         (halt),
    .stall        (stall),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .done         (done),
    .fsm_state    (fsm_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Builds the expected word list of one accepted commit from the record format.
  task automatic model_accept();
    logic [2:0]  k;
    logic [15:0] w[$];
    if (reg_write && mem_write)     k = 3'd3;
    else if (reg_write && mem_read) k = 3'd2;
    else if (reg_write)             k = 3'd1;
    else if (halt)                  k = 3'd5;
    else if (mem_write)             k = 3'd4;
    else                            k = 3'd0;
    w.push_back({k, write_reg, 10'b0});
    w.push_back(m_inum);
    w.push_back(pc);
    if (k == 3'd1 || k == 3'd2 || k == 3'd3) w.push_back(write_data);
    if (k == 3'd2 || k == 3'd3 || k == 3'd4) w.push_back(mem_addr);
    if (k == 3'd3 || k == 3'd4)              w.push_back(mem_data);
    foreach (w[i]) begin
      exp_q.push_back(w[i]);
      exp_last_q.push_back(i == w.size() - 1);
      exp_halt_q.push_back(k == 3'd5);
    end
    m_inum = m_inum + 16'd1;
    occ++;
    if (k == 3'd5) m_halted = 1'b1;
  endtask

  // Scoreboard / compare process, evaluated mid-cycle on stable signals.
  always @(negedge clk) begin
    logic        exp_stall;
    logic [15:0] w;
    logic        l;
    logic        h;
    if (!rst) begin
      exp_q.delete();
      exp_last_q.delete();
      exp_halt_q.delete();
      occ = 0;
      m_inum = '0;
      m_halted = 1'b0;
      m_done = 1'b0;
      prev_hold = 1'b0;
      chk("in_reset_outputs", {12'h0, stall, tx_valid, tx_last, done, tx_data}, 32'h0);
    end else begin
      exp_stall = (occ == DEPTH) && !m_halted;
      chk("stall", stall, exp_stall);
      chk("done", done, m_done);
      if (prev_hold) begin
        chk("hold_valid", tx_valid, 1'b1);
        chk("hold_data", tx_data, prev_data);
        chk("hold_last", tx_last, prev_last);
      end
      if (exp_q.size() == 0) begin
        chk("idle_valid", tx_valid, 1'b0);
      end else if (tx_valid && tx_ready) begin
        w = exp_q.pop_front();
        l = exp_last_q.pop_front();
        h = exp_halt_q.pop_front();
        chk("word", tx_data, w);
        chk("last", tx_last, l);
        got_q.push_back(tx_data);
        hs_count++;
        if (l) begin
          occ--;
          if (h) m_done = 1'b1;
        end
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      prev_last = tx_last;
      if (commit_valid && !exp_stall && !m_halted) model_accept();
    end
  end

  // Driver tasks
  task automatic set_commit(input logic [15:0] p, input logic rw, input logic [2:0] wr,
                            input logic [15:0] wd, input logic mr, input logic mw,
                            input logic [15:0] ma, input logic [15:0] md, input logic h);
    commit_valid = 1'b1;
    pc = p; reg_write = rw; write_reg = wr; write_data = wd;
    mem_read = mr; mem_write = mw; mem_addr = ma; mem_data = md; halt = h;
  endtask

  task automatic hold_until_accept(output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = !stall;
      @(posedge clk);
      #1;
      waited++;
    end
    chk("accept_timeout", acc, 1'b1);
    commit_valid = 1'b0;
  endtask

  task automatic commit(input logic [15:0] p, input logic rw, input logic [2:0] wr,
                        input logic [15:0] wd, input logic mr, input logic mw,
                        input logic [15:0] ma, input logic [15:0] md, input logic h);
    int n;
    set_commit(p, rw, wr, wd, mr, mw, ma, md, h);
    hold_until_accept(n);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    commit_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {12'h0, stall, tx_valid, tx_last, done, tx_data}, 32'h0);
    chk("async_reset_state", fsm_state, 3'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int sz;
    int base;
    rst = 1'b0;
    tx_ready = 1'b0;
    commit_valid = 1'b0;
    pc = '0; reg_write = 1'b0; write_reg = '0; write_data = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_data = '0; halt = 1'b0;

    // Power-on reset
    #2;
    chk("por_outputs", {12'h0, stall, tx_valid, tx_last, done, tx_data}, 32'h0);
    chk("por_state", fsm_state, 3'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;

    // LD interrupted by reset while its ADDR word is on the bus
    tx_ready = 1'b1;
    got_q.delete();
    commit(16'h0010, 1'b1, 3'd1, 16'hBEEF, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
    n = 0;
    while (got_q.size() < 4 && n < 50) begin @(posedge clk); #1; n++; end
    chk("ld_reached_addr", got_q.size(), 4);
    chk("ld_addr_word", tx_data, 16'h0040);
    apply_reset();

    // Single REG after reset release: numbering restarts at 0
    got_q.delete();
    commit(16'h0002, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    wait_drain("reg_drain");
    chk("reg_count", got_q.size(), 4);
    chk("reg_hdr", got_q[0], 16'h2C00);
    chk("reg_inum", got_q[1], 16'h0000);
    chk("reg_pc", got_q[2], 16'h0002);
    chk("reg_val", got_q[3], 16'h1234);
    chk("reg_done", done, 1'b0);

    // STU then ST queued, then streamed without a gap
    apply_reset();
    tx_ready = 1'b0;
    commit(16'h0100, 1'b1, 3'd5, 16'h1111, 1'b0, 1'b1, 16'h2222, 16'h3333, 1'b0);
    commit(16'h0102, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h4444, 16'h5555, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    got_q.delete();
    base = hs_count;
    tx_ready = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    chk("no_bubble", hs_count - base, 11);
    chk("stu_hdr", got_q[0], 16'h7400);
    chk("stu_inum", got_q[1], 16'h0000);
    chk("stu_mdata", got_q[5], 16'h3333);
    chk("st_hdr", got_q[6], 16'h8000);
    chk("st_inum", got_q[7], 16'h0001);
    chk("st_mdata", got_q[10], 16'h5555);
    wait_drain("stu_st_drain");

    // Back-pressure: five NOPs into a four-entry buffer with the sink stalled
    apply_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      commit(16'h0010 + 16'(i), 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("bp_stall_after4", stall, 1'b1);
    set_commit(16'h0014, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_stall_held", stall, 1'b1);
    got_q.delete();
    tx_ready = 1'b1;
    hold_until_accept(n);
    chk("bp_accept_delay", n, 4);
    wait_drain("bp_drain");
    chk("bp_word_count", got_q.size(), 15);
    chk("bp_fifth_inum", got_q[13], 16'h0004);

    // Seven mixed commits, HALT at inum 7, then commits that must be ignored
    apply_reset();
    tx_ready = 1'b1;
    got_q.delete();
    commit(16'h0100, 1'b1, 3'd1, 16'h00AA, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    commit(16'h0101, 1'b1, 3'd2, 16'h00BB, 1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0);
    commit(16'h0102, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0304, 16'h00CC, 1'b0);
    commit(16'h0103, 1'b1, 3'd4, 16'h00DD, 1'b0, 1'b1, 16'h0308, 16'h00EE, 1'b0);
    commit(16'h0104, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    commit(16'h0105, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 16'h030C, 16'h00FF, 1'b0);
    commit(16'h0106, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    commit(16'h0200, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++)
      commit(16'h0300 + 16'(i), 1'b1, 3'd6, 16'h0077, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    wait_drain("halt_drain");
    repeat (4) begin @(posedge clk); #1; end
    sz = got_q.size();
    chk("halt_total_words", sz, 34);
    chk("halt_hdr", got_q[sz-3], 16'hA000);
    chk("halt_inum", got_q[sz-2], 16'h0007);
    chk("halt_pc", got_q[sz-1], 16'h0200);
    chk("halt_done", done, 1'b1);
    chk("halt_quiet", {stall, tx_valid}, 2'b00);

    // inum wrap from 0xFFFF to 0x0000
    apply_reset();
    tx_ready = 1'b1;
    force dut.inum = 16'hFFFF;
    m_inum = 16'hFFFF;
    @(negedge clk);
    release dut.inum;
    @(posedge clk);
    #1;
    got_q.delete();
    commit(16'h0030, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    commit(16'h0031, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    wait_drain("wrap_drain");
    chk("wrap_inum_ffff", got_q[1], 16'hFFFF);
    chk("wrap_inum_0000", got_q[4], 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/commit_trace_tx.md
Name: commit_trace_tx

Overview:
- Hardware producer of the per-instruction commit trace, one record per retired instruction.
- Sits at the processor's writeback/commit point and accepts one commit per cycle.
- Classifies each commit the same way the trace bench does, numbers it, buffers it in a small FIFO, and serializes each record as 16-bit words over a valid/ready stream toward an off-chip logger.
- Back-pressures the core with a stall when the buffer is full.

Parameters:
- DEPTH, 4, record FIFO entries (power of two, at least 2).
- INUM_W, 16, instruction-number counter width; wraps modulo 2^INUM_W.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- commit_valid  in  1  an instruction commits this cycle.
- pc  in  16  PC of the committing instruction.
- reg_write  in  1  register file written.
- write_reg  in  3  destination register.
- write_data  in  16  register write value.
- mem_read  in  1  data memory read.
- mem_write  in  1  data memory write.
- mem_addr  in  16  memory address.
- mem_data  in  16  memory store data.
- halt  in  1  HALT committing.
- stall  out  1  FIFO full; the core must hold the commit.
- tx_data  out  16  stream word.
- tx_valid  out  1  tx_data valid.
- tx_last  out  1  final word of the current record.
- tx_ready  in  1  sink accepts the word.
- done  out  1  HALT record fully transmitted (sticky).

Behaviour:
- Reset: rst low clears all state asynchronously. While reset is asserted or immediately after release:
  - stall=0, tx_valid=0, tx_last=0, tx_data=0, done=0.
  - FIFO empty, inum=0, FSM in IDLE.
  - Any partially sent record is discarded; no resumption.
- Accept: a commit is accepted when commit_valid=1, stall=0, and halt has not yet been accepted.
  - On accept, push one entry {kind, write_reg, inum, pc, write_data, mem_addr, mem_data}, then increment inum.
  - The first instruction gets inum 0. Every accepted kind increments inum, including NOP/BR.
- Classification, priority order:
  - reg_write & mem_write -> STU
  - reg_write & mem_read -> LD
  - reg_write -> REG
  - halt -> HALT
  - mem_write -> ST
  - otherwise NOP
- Kind encoding: NOP=0, REG=1, LD=2, STU=3, ST=4, HALT=5.
- stall = FIFO full (registered count == DEPTH). A pop in the same cycle does not lower stall until the next cycle.
- After HALT is accepted, further commit_valid is ignored and stall stays 0.
- Record word sequence:
  - Every record starts with HDR, INUM, PC.
  - HDR = {kind[2:0], write_reg[2:0], 10'b0}. INUM = zero-extended inum.
  - NOP and HALT: 3 words (HDR, INUM, PC).
  - REG: 4 words (+VALUE).
  - LD: 5 words (+VALUE, ADDR).
  - ST: 5 words (+ADDR, MDATA).
  - STU: 6 words (+VALUE, ADDR, MDATA).
- Serializer FSM states: IDLE, HDR, INUM, PC, VAL, ADDR, MDATA, FIN.
  - IDLE -> HDR when the FIFO is non-empty; the head entry is latched into an output register.
  - Each state advances only on tx_valid & tx_ready.
  - PC goes to VAL (REG/LD/STU), ADDR (ST), or IDLE (NOP), or FIN (HALT).
  - The final word of each record asserts tx_last; its handshake pops the FIFO.
  - FIN sets done=1 and holds there with tx_valid=0 until reset.
- Stream rules:
  - tx_data and tx_last stay stable while tx_valid & !tx_ready.
  - tx_valid is never retracted before the handshake.
  - Back-to-back records have no idle cycle between them: the next HDR is valid in the cycle after the previous last handshake.
- Simultaneous push and pop: FIFO count is unchanged. A push when full is blocked because stall is high.
- inum wrap: 0xFFFF + 1 -> 0x0000, no flag.

Decomposition:
- commit_trace_pkg holds:
  - kind encodings and the FSM state enumeration;
  - ENTRY_W = 3+3+INUM_W+64;
  - per-kind word-count constant.
- Sub-module commit_trace_fifo: synchronous FIFO with DEPTH entries of ENTRY_W bits, push/pop/full/empty, async active-low reset.
- The classifier and serializer FSM stay in commit_trace_tx.

Test Plan:
- Reset mid-record: assert rst during the ADDR word of an LD -> all outputs 0 immediately; after release, the next commit is sent with inum 0.
- Single REG: pc=0x0002, write_reg=3, write_data=0x1234, tx_ready=1 -> words 0x2C00, 0x0000, 0x0002, 0x1234 with tx_last on the 4th; done stays 0.
- STU then ST with tx_ready=1 -> 6 words (HDR 0x6000|reg<<10) then 5 words (HDR 0x8000); INUMs 0 and 1; no bubble between the records.
- Back-pressure: tx_ready=0 while committing 5 NOPs at DEPTH=4 -> stall rises after the 4th accept and the 5th is held. After tx_ready=1, the 5th is accepted the cycle after the first pop; every word stays stable while stalled.
- HALT with reg_write=0 at inum 7, followed by extra commits -> 3 words (0xA000, 0x0007, pc); done=1 after the last handshake; the extra commits produce no records.
- Wrap: preload 0xFFFF commits (or force the counter) -> consecutive INUM words 0xFFFF then 0x0000.
